// File: rtl/l2_pkg.sv
// Shared types and constants for the layer-2 command controller.
package l2_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR_LEN = 3'd1,
      LAUNCH  = 3'd2,
      WAIT    = 3'd3,
      STATUS  = 3'd4
   } l2_state_e;

   typedef struct packed {
      logic [BYTE_W-1:0] cmd;
      logic [BYTE_W-1:0] len;
   } l2_hdr_t;

   localparam logic [BYTE_W-1:0] ST_OK      = 8'h00;
   localparam logic [BYTE_W-1:0] ST_L3_ERR  = 8'h01;
   localparam logic [BYTE_W-1:0] ST_TIMEOUT = 8'h02;
   localparam logic [BYTE_W-1:0] ST_ABORT   = 8'h03;
   localparam logic [BYTE_W-1:0] ST_BAD_LEN = 8'h04;

endpackage

// File: rtl/l2_cmd_ctrl_if.sv
// Bundle of FIFO, layer-3, watchdog and debug signals around the layer-2 controller.
interface l2_cmd_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   import l2_pkg::*;

   logic              spi_cs_n;
   logic              rx_empty;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_rd;
   logic              l3_en;
   logic [BYTE_W-1:0] l3_cmd;
   logic [BYTE_W-1:0] l3_len;
   logic              l3_cmd_done;
   logic              l3_err;
   logic              err_timeout;
   logic              timer_stop;
   logic              tx_full;
   logic              tx_wr;
   logic [BYTE_W-1:0] tx_data;
   logic              busy;
   logic [CNT_W-1:0]  cmd_cnt;
   logic [BYTE_W-1:0] err_cnt;

   modport master (
      input  spi_cs_n, rx_empty, rx_data, l3_cmd_done, l3_err, err_timeout, tx_full,
      output rx_rd, l3_en, l3_cmd, l3_len, timer_stop, tx_wr, tx_data, busy,
             cmd_cnt, err_cnt
   );

   modport slave (
      output spi_cs_n, rx_empty, rx_data, l3_cmd_done, l3_err, err_timeout, tx_full,
      input  rx_rd, l3_en, l3_cmd, l3_len, timer_stop, tx_wr, tx_data, busy,
             cmd_cnt, err_cnt
   );

endinterface

// File: rtl/l2_stat_cnt.sv
// Debug counters: wrapping count of status bytes written, saturating count of error statuses.
module l2_stat_cnt
   import l2_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_i,
   input  logic [BYTE_W-1:0] status_i,
   output logic [CNT_W-1:0]  cmd_cnt_o,
   output logic [BYTE_W-1:0] err_cnt_o
);

   logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
   logic [BYTE_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      cmd_cnt_d = cmd_cnt_q;
      err_cnt_d = err_cnt_q;
      if (wr_i) begin
         cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
         if ((status_i != ST_OK) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + BYTE_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         cmd_cnt_q <= cmd_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign cmd_cnt_o = cmd_cnt_q;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/l2_cmd_ctrl.sv
// Layer-2 command controller: pops a (cmd, len) header, launches layer 3, and
// reports one status byte per command to the TX FIFO.
module l2_cmd_ctrl
   import l2_pkg::*;
#(
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   l2_cmd_ctrl_if.master bus
);

   localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

   l2_state_e         state_q, state_d;
   l2_hdr_t           hdr_q, hdr_d;
   logic [BYTE_W-1:0] status_q, status_d;
   logic              timer_stop_q, timer_stop_d;
   logic              pop_c;
   logic              wr_c;

   always_comb begin
      state_d      = state_q;
      hdr_d        = hdr_q;
      status_d     = status_q;
      timer_stop_d = 1'b0;
      pop_c        = 1'b0;
      wr_c         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!bus.rx_empty && !bus.spi_cs_n) begin
               pop_c     = 1'b1;
               hdr_d.cmd = bus.rx_data;
               state_d   = HDR_LEN;
            end
         end
         HDR_LEN: begin
            // A frame ending mid-header drops the partial header silently.
            if (bus.spi_cs_n) begin
               state_d = IDLE;
            end else if (!bus.rx_empty) begin
               pop_c     = 1'b1;
               hdr_d.len = bus.rx_data;
               if ((bus.rx_data == '0) || (bus.rx_data > MAX_LEN_B)) begin
                  status_d = ST_BAD_LEN;
                  state_d  = STATUS;
               end else begin
                  state_d  = LAUNCH;
               end
            end
         end
         LAUNCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            // Completion wins over a coincident watchdog expiry.
            if (bus.l3_cmd_done) begin
               status_d = bus.l3_err ? ST_L3_ERR : ST_OK;
               state_d  = STATUS;
            end else if (bus.err_timeout) begin
               status_d = ST_TIMEOUT;
               state_d  = STATUS;
            end else if (bus.spi_cs_n) begin
               status_d     = ST_ABORT;
               timer_stop_d = 1'b1;
               state_d      = STATUS;
            end
         end
         STATUS: begin
            if (!bus.tx_full) begin
               wr_c    = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         hdr_q        <= '0;
         status_q     <= ST_OK;
         timer_stop_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         status_q     <= status_d;
         timer_stop_q <= timer_stop_d;
      end
   end

   l2_stat_cnt #(
      .CNT_W (CNT_W)
   ) u_stat (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_i      (wr_c),
      .status_i  (status_q),
      .cmd_cnt_o (bus.cmd_cnt),
      .err_cnt_o (bus.err_cnt)
   );

   assign bus.rx_rd      = pop_c;
   assign bus.l3_en      = (state_q == LAUNCH);
   assign bus.l3_cmd     = hdr_q.cmd;
   assign bus.l3_len     = hdr_q.len;
   assign bus.timer_stop = timer_stop_q;
   assign bus.tx_wr      = wr_c;
   assign bus.tx_data    = status_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_l2_cmd_ctrl.sv
// Scoreboard bench for l2_cmd_ctrl: directed scenarios followed by random commands.
module tb_l2_cmd_ctrl;
   import l2_pkg::*;

   localparam int unsigned MAX_LEN = 64;
   localparam int unsigned CNT_W   = 16;

   typedef struct {
      logic [7:0] status;
      int         exp_cyc;
   } exp_st_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   l2_cmd_ctrl_if #(.CNT_W(CNT_W)) bus ();

   l2_cmd_ctrl #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   exp_st_t     st_q[$];
   logic [15:0] launch_q[$];
   int          ts_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          model_cmd = 0;
   int          model_err = 0;
   bit          cnt_pending = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // RX FIFO model: array plus pointers, popped on rx_rd at the clock edge
   logic [7:0] rx_mem [256];
   int         rx_wr_ptr = 0;
   int         rx_rd_ptr = 0;

   always @(posedge clk) begin
      if (!rst_n)          rx_rd_ptr <= rx_wr_ptr;
      else if (bus.rx_rd)  rx_rd_ptr <= rx_rd_ptr + 1;
   end
   assign bus.rx_empty = (rx_rd_ptr == rx_wr_ptr);
   assign bus.rx_data  = rx_mem[8'(rx_rd_ptr)];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void fail_ev(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got 1 expected 0 (cycle %0d)", name, cyc);
   endfunction

   // Monitor: compares every DUT event against the scoreboard queues
   always @(negedge clk) begin
      exp_st_t     e;
      logic [15:0] h;
      if (rst_n) begin
         if (cnt_pending) begin
            chk("cmd_cnt", 32'(bus.cmd_cnt), 32'(model_cmd));
            chk("err_cnt", 32'(bus.err_cnt), 32'(model_err));
            cnt_pending = 1'b0;
         end
         if (bus.tx_full) chk("tx_wr_while_full", 32'(bus.tx_wr), 32'd0);
         if (bus.l3_en) begin
            if (launch_q.size() == 0) fail_ev("unexpected_l3_en");
            else begin
               h = launch_q.pop_front();
               chk("l3_cmd", 32'(bus.l3_cmd), 32'(h[15:8]));
               chk("l3_len", 32'(bus.l3_len), 32'(h[7:0]));
            end
         end
         if (bus.tx_wr) begin
            if (st_q.size() == 0) fail_ev("unexpected_tx_wr");
            else begin
               e = st_q.pop_front();
               chk("tx_data", 32'(bus.tx_data), 32'(e.status));
               if (e.exp_cyc >= 0) chk("tx_wr_cycle", 32'(cyc), 32'(e.exp_cyc));
               model_cmd = (model_cmd + 1) % (1 << CNT_W);
               if (e.status != 8'h00 && model_err < 255) model_err++;
               cnt_pending = 1'b1;
            end
         end
         if (bus.timer_stop) begin
            if (ts_q.size() == 0) fail_ev("unexpected_timer_stop");
            else chk("timer_stop_cycle", 32'(cyc), 32'(ts_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rx(input logic [7:0] b);
      rx_mem[8'(rx_wr_ptr)] = b;
      rx_wr_ptr++;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && st_q.size() != 0; i++) tick();
      if (st_q.size() != 0) begin
         fail_ev("status_write_timeout");
         st_q.delete();
      end
      tick();
   endtask

   task automatic wait_launch(output bit found);
      found = 1'b0;
      for (int i = 1; i <= 20 && !found; i++) begin
         tick();
         if (bus.l3_en) begin
            found = 1'b1;
            chk("l3_en_latency", 32'(i), 32'd2);
         end
      end
      if (!found) fail_ev("l3_en_timeout");
   endtask

   // outcome: 0 done, 1 timeout, 2 done+timeout collision, 3 chip-select abort
   task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] len, input int outcome,
                          input int delay, input int stall, input logic err);
      bit         legal;
      bit         found;
      int         n;
      logic [7:0] exp;
      legal = (len != 8'd0) && (len <= 8'(MAX_LEN));
      if (!legal) begin
         st_q.push_back('{ST_BAD_LEN, -1});
         push_rx(cmd);
         push_rx(len);
         wait_drain();
         return;
      end
      launch_q.push_back({cmd, len});
      push_rx(cmd);
      push_rx(len);
      wait_launch(found);
      if (!found) return;
      repeat (delay) tick();
      if (stall > 0) bus.tx_full = 1'b1;
      n = cyc;
      case (outcome)
         0: begin bus.l3_cmd_done = 1'b1; bus.l3_err = err; exp = err ? 8'h01 : 8'h00; end
         1: begin bus.err_timeout = 1'b1; exp = 8'h02; end
         2: begin bus.l3_cmd_done = 1'b1; bus.err_timeout = 1'b1; bus.l3_err = err;
                  exp = err ? 8'h01 : 8'h00; end
         default: begin bus.spi_cs_n = 1'b1; exp = 8'h03; ts_q.push_back(n + 1); end
      endcase
      st_q.push_back('{exp, n + ((stall > 0) ? stall : 1)});
      tick();
      bus.l3_cmd_done = 1'b0;
      bus.err_timeout = 1'b0;
      bus.l3_err      = 1'b0;
      bus.spi_cs_n    = 1'b0;
      if (stall > 1) repeat (stall - 1) tick();
      bus.tx_full = 1'b0;
      wait_drain();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      model_cmd   = 0;
      model_err   = 0;
      cnt_pending = 1'b0;
      chk("rst_busy",       32'(bus.busy), 32'd0);
      chk("rst_l3_en",      32'(bus.l3_en), 32'd0);
      chk("rst_rx_rd",      32'(bus.rx_rd), 32'd0);
      chk("rst_tx_wr",      32'(bus.tx_wr), 32'd0);
      chk("rst_timer_stop", 32'(bus.timer_stop), 32'd0);
      chk("rst_l3_cmd",     32'(bus.l3_cmd), 32'd0);
      chk("rst_l3_len",     32'(bus.l3_len), 32'd0);
      chk("rst_tx_data",    32'(bus.tx_data), 32'd0);
      chk("rst_cmd_cnt",    32'(bus.cmd_cnt), 32'd0);
      chk("rst_err_cnt",    32'(bus.err_cnt), 32'd0);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic idle_noise();
      bus.l3_cmd_done = 1'b1;
      bus.err_timeout = 1'b1;
      tick();
      bus.l3_cmd_done = 1'b0;
      bus.err_timeout = 1'b0;
      tick();
      chk("busy_after_idle_noise", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      bit found;
      bus.spi_cs_n    = 1'b0;
      bus.l3_cmd_done = 1'b0;
      bus.l3_err      = 1'b0;
      bus.err_timeout = 1'b0;
      bus.tx_full     = 1'b0;
      do_reset();

      // Normal command, completion 5 cycles after launch
      run_cmd(8'h85, 8'h10, 0, 5, 0, 1'b0);
      chk("normal_cmd_cnt", 32'(bus.cmd_cnt), 32'd1);
      chk("normal_err_cnt", 32'(bus.err_cnt), 32'd0);

      // Illegal lengths
      run_cmd(8'h11, 8'h00, 0, 1, 0, 1'b0);
      run_cmd(8'h12, 8'd65, 0, 1, 0, 1'b0);
      chk("badlen_err_cnt", 32'(bus.err_cnt), 32'd2);
      run_cmd(8'h13, 8'd64, 0, 1, 0, 1'b0);
      run_cmd(8'h14, 8'd1,  0, 1, 0, 1'b1);

      // Timeout, collision, abort
      run_cmd(8'h21, 8'h08, 1, 3, 0, 1'b0);
      run_cmd(8'h22, 8'h08, 2, 2, 0, 1'b1);
      run_cmd(8'h23, 8'h08, 3, 2, 0, 1'b0);

      // Frame ends mid-header
      push_rx(8'h31);
      tick();
      chk("busy_in_hdr", 32'(bus.busy), 32'd1);
      bus.spi_cs_n = 1'b1;
      tick();
      chk("busy_after_hdr_abort", 32'(bus.busy), 32'd0);
      bus.spi_cs_n = 1'b0;
      tick();
      chk("busy_idle_after_hdr_abort", 32'(bus.busy), 32'd0);

      // TX backpressure
      run_cmd(8'h41, 8'h20, 0, 1, 10, 1'b0);
      idle_noise();

      // Reset during WAIT
      launch_q.push_back({8'h51, 8'h04});
      push_rx(8'h51);
      push_rx(8'h04);
      wait_launch(found);
      tick();
      rst_n = 1'b0;
      tick();
      model_cmd = 0;
      model_err = 0;
      cnt_pending = 1'b0;
      tick();
      chk("rstwait_busy",    32'(bus.busy), 32'd0);
      chk("rstwait_cmd_cnt", 32'(bus.cmd_cnt), 32'd0);
      chk("rstwait_err_cnt", 32'(bus.err_cnt), 32'd0);
      chk("rstwait_tx_wr",   32'(bus.tx_wr), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();

      // Error counter saturation
      for (int i = 0; i < 300; i++) begin
         int k;
         k = int'($urandom_range(0, 3));
         case (k)
            0: run_cmd(8'($urandom), 8'h00, 0, 1, 0, 1'b0);
            1: run_cmd(8'($urandom), 8'(65 + $urandom_range(0, 190)), 0, 1, 0, 1'b0);
            2: run_cmd(8'($urandom), 8'($urandom_range(1, 64)), 1, 1, 0, 1'b0);
            default: run_cmd(8'($urandom), 8'($urandom_range(1, 64)), 0, 1, 0, 1'b1);
         endcase
      end
      chk("err_cnt_saturated", 32'(bus.err_cnt), 32'd255);

      // Command counter wrap
      force dut.u_stat.cmd_cnt_q = 16'hFFFF;
      tick();
      release dut.u_stat.cmd_cnt_q;
      model_cmd = 65535;
      run_cmd(8'h61, 8'h02, 0, 1, 0, 1'b0);
      chk("cmd_cnt_wrap", 32'(bus.cmd_cnt), 32'd0);

      // Random mix
      for (int i = 0; i < 150; i++) begin
         int         r;
         logic [7:0] len;
         r = int'($urandom_range(0, 9));
         case (r)
            0:       len = 8'h00;
            1:       len = 8'(65 + $urandom_range(0, 190));
            2:       len = 8'd64;
            3:       len = 8'd1;
            default: len = 8'($urandom_range(1, 64));
         endcase
         run_cmd(8'($urandom), len, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 9) == 0) idle_noise();
      end

      repeat (5) tick();
      chk("launch_q_drained", 32'(launch_q.size()), 32'd0);
      chk("timer_stop_q_drained", 32'(ts_q.size()), 32'd0);
      chk("final_busy", 32'(bus.busy), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
